// File: rtl/div_period_meter.sv
// div_period_meter: measures the period of a slow divided clock SIG in cycles of IPTCLK.
// SIG is synchronized, rising edges are detected, and the count between consecutive
// rises is reported on PERIOD with a one-cycle VALID strobe. Counts saturate at all-ones.
// Optional feature macro: HIGHTIME_EN adds a high-time counter and the HIGHT output.
module div_period_meter #(
    parameter int unsigned CW = 16
) (
    input  logic          IPTCLK,
    input  logic          IPTRST,
    input  logic          SIG,
`ifdef HIGHTIME_EN
    output logic [CW-1:0] HIGHT,
`endif
    output logic [CW-1:0] PERIOD,
    output logic          VALID,
    output logic          OVF
);

    localparam logic [CW-1:0] CntMax = '1;
    localparam logic [CW-1:0] CntOne = CW'(1);

    typedef enum logic {StIdle, StRun} state_e;

    state_e        state_q, state_d;
    logic          s1, s2, s3;
    logic          rise;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sat_q, sat_d;
    logic [CW-1:0] period_q, period_d;
    logic          ovf_q, ovf_d;
    logic          valid_q, valid_d;

`ifdef HIGHTIME_EN
    logic [CW-1:0] hcnt_q, hcnt_d;
    logic [CW-1:0] hight_q, hight_d;
`endif

    // Two-flop synchronizer plus one delay stage for edge detection
    always_ff @(posedge IPTCLK or posedge IPTRST) begin
        if (IPTRST) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= SIG;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

    // Next-state and result logic; the counter saturates instead of wrapping
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sat_d    = sat_q;
        period_d = period_q;
        ovf_d    = ovf_q;
        valid_d  = 1'b0;
`ifdef HIGHTIME_EN
        hight_d  = hight_q;
`endif
        case (state_q)
            StIdle: begin
                // First rise only starts the measurement
                if (rise) begin
                    state_d = StRun;
                    cnt_d   = CntOne;
                    sat_d   = 1'b0;
                end
            end
            StRun: begin
                if (rise) begin
                    period_d = cnt_q;
                    // A count that reached all-ones is reported as overflow even when
                    // the rise lands exactly on the saturating cycle
                    ovf_d    = sat_q | (cnt_q == CntMax);
                    valid_d  = 1'b1;
`ifdef HIGHTIME_EN
                    hight_d  = hcnt_q;
`endif
                    cnt_d    = CntOne;
                    sat_d    = 1'b0;
                end else if (cnt_q != CntMax) begin
                    cnt_d = cnt_q + CntOne;
                end else begin
                    sat_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

`ifdef HIGHTIME_EN
    // High-time counter: restarts on each rise, accumulates cycles with s2 high
    always_comb begin
        hcnt_d = hcnt_q;
        if (rise) begin
            hcnt_d = CntOne;
        end else if (s2 && (hcnt_q != CntMax)) begin
            hcnt_d = hcnt_q + CntOne;
        end
    end

    // High-time state and result registers
    always_ff @(posedge IPTCLK or posedge IPTRST) begin
        if (IPTRST) begin
            hcnt_q  <= '0;
            hight_q <= '0;
        end else begin
            hcnt_q  <= hcnt_d;
            hight_q <= hight_d;
        end
    end

    assign HIGHT = hight_q;
`endif

    // Measurement state and result registers
    always_ff @(posedge IPTCLK or posedge IPTRST) begin
        if (IPTRST) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            sat_q    <= 1'b0;
            period_q <= '0;
            ovf_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sat_q    <= sat_d;
            period_q <= period_d;
            ovf_q    <= ovf_d;
            valid_q  <= valid_d;
        end
    end

    assign PERIOD = period_q;
    assign VALID  = valid_q;
    assign OVF    = ovf_q;

endmodule

// File: tb/tb_div_period_meter.sv
// tb_div_period_meter: scoreboard bench for div_period_meter (CW = 4).
// The driver models each SIG rise and queues the expected result; a negedge monitor
// pops and compares whenever VALID is seen. Define HIGHTIME_EN to also check HIGHT.
module tb_div_period_meter;

    localparam int unsigned CW   = 4;
    localparam int unsigned CMAX = (1 << CW) - 1;

    logic          IPTCLK;
    logic          IPTRST;
    logic          SIG;
    logic [CW-1:0] PERIOD;
    logic          VALID;
    logic          OVF;
`ifdef HIGHTIME_EN
    logic [CW-1:0] HIGHT;
`endif

    div_period_meter #(.CW(CW)) dut (
        .IPTCLK (IPTCLK),
        .IPTRST (IPTRST),
        .SIG    (SIG),
`ifdef HIGHTIME_EN
        .HIGHT  (HIGHT),
`endif
        .PERIOD (PERIOD),
        .VALID  (VALID),
        .OVF    (OVF)
    );

    typedef struct {
        int unsigned cyc;
        int unsigned period;
        int unsigned ovf;
        int unsigned hight;
    } exp_t;

    exp_t        q[$];
    int unsigned cyc = 0;
    int unsigned total = 0;
    int unsigned bad = 0;
    bit          armed = 0;
    int unsigned last_rise = 0;
    int unsigned hi = 0;
    int unsigned last_per = 0;
    int unsigned last_ovf = 0;

    initial IPTCLK = 1'b0;
    always #5 IPTCLK = ~IPTCLK;

    always @(posedge IPTCLK) cyc <= cyc + 1;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive SIG for one cycle; on a 0->1 transition queue the expected result
    task automatic step(input logic v);
        int unsigned per;
        exp_t        e;
        @(posedge IPTCLK);
        #1;
        if (v && !SIG) begin
            if (armed) begin
                per      = cyc - last_rise;
                e.cyc    = cyc + 3;
                e.period = (per >= CMAX) ? CMAX : per;
                e.ovf    = (per >= CMAX) ? 1 : 0;
                e.hight  = (hi >= CMAX) ? CMAX : hi;
                q.push_back(e);
                last_per = e.period;
                last_ovf = e.ovf;
            end
            armed     = 1;
            last_rise = cyc;
            hi        = 0;
        end
        SIG = v;
        if (v) hi++;
    endtask

    task automatic wave(input int h, input int l, input int n);
        repeat (n) begin
            repeat (h) step(1'b1);
            repeat (l) step(1'b0);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_period"}, PERIOD, 0);
        chk({tag, "_valid"}, VALID, 0);
        chk({tag, "_ovf"}, OVF, 0);
`ifdef HIGHTIME_EN
        chk({tag, "_hight"}, HIGHT, 0);
`endif
    endtask

    // Monitor: compare each VALID against the head of the scoreboard
    always @(negedge IPTCLK) begin
        exp_t e;
        if (!IPTRST) begin
            if (VALID) begin
                if (q.size() == 0) begin
                    chk("spurious_valid", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("valid_cycle", cyc, e.cyc);
                    chk("period", PERIOD, e.period);
                    chk("ovf", OVF, e.ovf);
`ifdef HIGHTIME_EN
                    chk("hight", HIGHT, e.hight);
`endif
                end
            end else if (q.size() != 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                chk("missed_valid", 0, 1);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        IPTRST = 1'b1;
        SIG    = 1'b0;
        #2;
        chk_zero("reset");
        @(posedge IPTCLK);
        #1 IPTRST = 1'b0;

        wave(1, 1, 6);      // div-by-2
        wave(2, 2, 4);      // div-by-4
        wave(4, 4, 4);      // div-by-8
        wave(3, 4, 4);      // period 7, high 3
        wave(10, 10, 3);    // period 20 saturates
        wave(3, 3, 3);      // period 6 after saturation
        wave(7, 8, 2);      // exactly all-ones: overflow
        wave(7, 7, 2);      // one below all-ones: no overflow
        wave(17, 3, 2);     // high time saturates
        wave(4, 4, 3);

        // Reset 3 cycles after a rise in a div-by-8 run
        step(1'b1);
        repeat (3) step(1'b1);
        #2;
        IPTRST = 1'b1;
        SIG    = 1'b0;
        q.delete();
        armed  = 0;
        #1;
        chk_zero("midreset");
        @(posedge IPTCLK);
        @(posedge IPTCLK);
        #1 IPTRST = 1'b0;
        wave(4, 4, 2);      // first rise silent, second reports 8

        // Stuck high then stuck low: only the entering rise reports
        repeat (100) step(1'b1);
        repeat (100) step(1'b0);
        repeat (4) @(posedge IPTCLK);
        #1;
        chk("stuck_period", PERIOD, last_per);
        chk("stuck_ovf", OVF, last_ovf);
        chk("stuck_last_per_is_8", last_per, 8);
        chk("pending_results", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/div_period_meter.md
# div_period_meter

Measures the period of a slow, divided clock signal (a 1:2, 1:4 or deeper output of the binary divider chain) in cycles of the master clock IPTCLK. It consumes a divided signal that the divider chain produces. The input is synchronized, and each rising edge is detected. The block reports the cycle count between consecutive rising edges as a registered word with a one-cycle valid strobe. It sits beside the divider chain as its self-check and readback path.

## Interface

- CW, 16: width of the period counter and result words; minimum 2.

- IPTCLK  input  1  master clock; all state updates on its rising edge.
- IPTRST  input  1  reset, asynchronous, active-high.
- SIG  input  1  divided signal to measure; may be asynchronous to IPTCLK.
- PERIOD  output  CW  cycles between the last two rising edges of SIG; holds between updates.
- VALID  output  1  one-cycle pulse when PERIOD, OVF (and HIGHT) update.
- OVF  output  1  set with VALID when the measured period saturated; holds between updates.
- HIGHT  output  CW  high-time count of the last period; present only with HIGHTIME_EN.

## Operation

- **Synchronizer:** SIG passes through two flops (s1, s2), then a third flop s3.
  - rise = s2 & ~s3.
- **States:**
  - IDLE: entered on reset. Waits for the first rise; no result is produced.
  - RUN: measuring.
- **IDLE transition:** on rise, go to RUN, cnt <= 1, sat <= 0.
- **RUN, no rise:**
  - If cnt < 2^CW-1, cnt <= cnt+1.
  - Otherwise cnt holds at all-ones and sat <= 1.
- **RUN, rise:**
  - PERIOD <= cnt, OVF <= sat, VALID <= 1.
  - Then cnt <= 1, sat <= 0. Stay in RUN.
- **VALID:** low in every cycle that has no update.
- **Saturation:** a period of 2^CW-1 cycles or more reports PERIOD = 2^CW-1 and OVF = 1.
  - A period of exactly 2^CW-1 cycles also reports OVF = 1.
  - The counter never wraps.
- **Minimum period:** 2 cycles (SIG toggling every IPTCLK). Shorter pulses are not resolved.
- **Constant SIG (high or low):** no rise, so no VALID. In RUN, cnt saturates and waits.
- **Reset:** asserting IPTRST at any time clears everything immediately.
  - State returns to IDLE.
  - s1/s2/s3, cnt and sat are cleared.
  - PERIOD = 0, OVF = 0, VALID = 0, HIGHT = 0.
  - The first rise after reset release restarts the measurement and produces no VALID.

## Timing

- **Reset values:** PERIOD = 0, VALID = 0, OVF = 0, HIGHT = 0, state IDLE.
- **Latency:** consider a SIG rising transition that is stable before IPTCLK edge k.
  - s1 captures it at edge k and s2 at edge k+1.
  - rise is true in the cycle after edge k+1.
  - VALID and PERIOD are registered at edge k+2 and visible until edge k+3.
- **Asynchronous SIG:** may add one cycle of uncertainty per edge. The long-run average of PERIOD is still correct.
- **Outputs:** all are registered and have no combinational path from SIG.

## Configuration

- **HIGHTIME_EN defined:**
  - Adds the hcnt counter and the HIGHT port.
  - On rise, hcnt <= 1. Otherwise hcnt <= hcnt + s2, saturating at all-ones.
  - On rise in RUN, HIGHT <= hcnt together with PERIOD.
  - This gives the number of cycles s2 was high within the reported period.
- **HIGHTIME_EN not defined:** no hcnt and no HIGHT port. All other behaviour is identical.

## Test plan

- **Div-by-2:** drive SIG synchronously from a divide-by-2 of IPTCLK and release reset.
  - No VALID is produced for the first rise.
  - Afterwards, VALID pulses every 2 cycles with PERIOD = 2, OVF = 0, HIGHT = 1.
- **Div-by-4 and div-by-8, 50% duty:**
  - Div-by-4 gives PERIOD = 4, HIGHT = 2.
  - Div-by-8 gives PERIOD = 8, HIGHT = 4.
  - VALID pulses once per period, each pulse exactly 1 cycle wide.
- **Asymmetric input:** period 7, high for 3 cycles.
  - PERIOD = 7, HIGHT = 3.
  - Latency from the SIG edge to VALID is exactly 2 IPTCLK edges (k+2).
- **Saturation (CW = 4):**
  - A 20-cycle period gives PERIOD = 15, OVF = 1.
  - A following 6-cycle period gives PERIOD = 6, OVF = 0.
- **Reset mid-measurement:** assert IPTRST 3 cycles after a rise during a div-by-8 run.
  - All outputs go to 0 immediately.
  - After release, the first rise gives no VALID.
  - The second rise gives PERIOD = 8.
- **Stuck input:** hold SIG high, then low, for 100 cycles each.
  - No VALID is produced.
  - PERIOD and OVF keep their last values.
